// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round constants, initial hash values,
// compression helper functions and the core's state encoding.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } vars_t;

  localparam vars_t IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam vars_t IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise modular add used when folding a block into the chaining value.
  function automatic vars_t add_vars(input vars_t x, input vars_t y);
    vars_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: (a..h, Kt, Wt) -> (a..h)'.
module sha2_round
  import sha2_pkg::*;
(
  input  vars_t       cur,
  input  logic [31:0] kt,
  input  logic [31:0] wt,
  output vars_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + kt + wt;
  assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

  assign nxt.a = t1 + t2;
  assign nxt.b = cur.a;
  assign nxt.c = cur.b;
  assign nxt.d = cur.c;
  assign nxt.e = cur.d + t1;
  assign nxt.f = cur.e;
  assign nxt.g = cur.f;
  assign nxt.h = cur.g;

endmodule

// File: rtl/sha2_core_mb.sv
// Multi-block SHA-224/SHA-256 compression core with UNROLL rounds per clock,
// block input handshake and held digest output handshake.
module sha2_core_mb
  import sha2_pkg::*;
#(
  parameter int MODE   = 256,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         hash_done,
  output logic         s_valid,
  input  logic         s_ready,
  output logic [255:0] s_data
);

  generate
    if (MODE != 256 && MODE != 224) begin : g_bad_mode
      $error("sha2_core_mb: MODE must be 224 or 256");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha2_core_mb: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam vars_t IV = (MODE == 224) ? IV_224 : IV_256;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        last_blk;
  vars_t       hv;
  vars_t       wv;
  logic [31:0] w     [16];
  logic [31:0] ext   [16+UNROLL];
  logic [31:0] kt    [UNROLL];
  vars_t       chain [UNROLL+1];

  // Extend the window by UNROLL schedule words; later ones feed on earlier ones.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
  end

  assign chain[0] = wv;

  generate
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
      assign kt[g] = K[cnt + 6'(g)];
      sha2_round u_round (
        .cur (chain[g]),
        .kt  (kt[g]),
        .wt  (w[g]),
        .nxt (chain[g+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (blk_valid) state_nxt = ST_ROUND;
      ST_ROUND:  if (cnt == 6'(64 - UNROLL)) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = last_blk ? ST_DONE : ST_IDLE;
      ST_DONE:   if (s_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv       <= IV;
      wv       <= '0;
      cnt      <= '0;
      last_blk <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) w[i] <= blk_data[511-32*i -: 32];
            cnt      <= '0;
            last_blk <= blk_last;
            if (blk_first) begin
              hv <= IV;
              wv <= IV;
            end else begin
              wv <= hv;
            end
          end
        end
        ST_ROUND: begin
          wv  <= chain[UNROLL];
          cnt <= cnt + 6'(UNROLL);
          for (int i = 0; i < 16; i++) w[i] <= ext[i+UNROLL];
        end
        ST_UPDATE: hv <= add_vars(hv, wv);
        default: ;
      endcase
    end
  end

  assign blk_ready = (state == ST_IDLE);
  assign hash_done = (state == ST_UPDATE);
  assign s_valid   = (state == ST_DONE);

  generate
    if (MODE == 224) begin : g_out224
      assign s_data = {hv[255:32], 32'h0};
    end else begin : g_out256
      assign s_data = hv;
    end
  endgenerate

endmodule

// File: tb/tb_sha2_core_mb.sv
// Directed bench for sha2_core_mb: known SHA-256/224 vectors across unroll
// factors, output hold, reset mid-block and message restart.
module tb_sha2_core_mb;
  import sha2_pkg::*;

  localparam int N = 5;
  localparam int MODES [N] = '{256, 256, 256, 256, 224};
  localparam int UNRS  [N] = '{1, 2, 4, 8, 1};

  localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] IV256_D = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224_D = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_00000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid [N];
  logic         blk_ready [N];
  logic [511:0] blk_data  [N];
  logic         blk_first [N];
  logic         blk_last  [N];
  logic         hash_done [N];
  logic         s_valid   [N];
  logic         s_ready   [N];
  logic [255:0] s_data    [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      sha2_core_mb #(.MODE(MODES[g]), .UNROLL(UNRS[g])) u_dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid[g]),
        .blk_ready (blk_ready[g]),
        .blk_data  (blk_data[g]),
        .blk_first (blk_first[g]),
        .blk_last  (blk_last[g]),
        .hash_done (hash_done[g]),
        .s_valid   (s_valid[g]),
        .s_ready   (s_ready[g]),
        .s_data    (s_data[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block, then follow it to s_valid (last) or blk_ready (not last).
  task automatic send_block(input int idx, input logic [511:0] d, input logic f, input logic l,
                            output int edges, output int dones, output int busy);
    check("ready_before_accept", 256'(blk_ready[idx]), 256'd1);
    blk_data[idx]  = d;
    blk_first[idx] = f;
    blk_last[idx]  = l;
    blk_valid[idx] = 1'b1;
    @(posedge clk); #1;
    blk_valid[idx] = 1'b0;
    edges = 0;
    dones = 0;
    busy  = 0;
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (hash_done[idx]) dones++;
      if (l ? s_valid[idx] : blk_ready[idx]) break;
      if (blk_ready[idx]) busy++;
    end
  endtask

  int e, d, b, d1;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      blk_valid[i] = 1'b0;
      blk_data[i]  = '0;
      blk_first[i] = 1'b0;
      blk_last[i]  = 1'b0;
      s_ready[i]   = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_ready",  256'(blk_ready[0]), 256'd1);
    check("rst_svalid", 256'(s_valid[0]),   256'd0);
    check("rst_done",   256'(hash_done[0]), 256'd0);
    check("rst_data256", s_data[0], IV256_D);
    check("rst_data224", s_data[4], IV224_D);

    // SHA-256 "abc", s_ready already high when DONE is entered
    send_block(0, ABC, 1'b1, 1'b1, e, d, b);
    check("abc_latency", 256'(e), 256'd65);
    check("abc_dones",   256'(d), 256'd1);
    check("abc_busy",    256'(b), 256'd0);
    check("abc_digest",  s_data[0], ABC_D);
    @(posedge clk); #1;
    check("abc_idle_after_hs", 256'({s_valid[0], blk_ready[0]}), 256'd1);

    // SHA-224 "abc"
    send_block(4, ABC, 1'b1, 1'b1, e, d, b);
    check("abc224_latency", 256'(e), 256'd65);
    check("abc224_digest",  s_data[4], ABC_224);
    @(posedge clk); #1;

    // Two-block message at every unroll factor
    for (int i = 0; i < 4; i++) begin
      send_block(i, TWO1, 1'b1, 1'b0, e, d1, b);
      check("two_b1_ready_back", 256'(e), 256'(64 / UNRS[i] + 1));
      check("two_b1_busy", 256'(b), 256'd0);
      send_block(i, TWO2, 1'b0, 1'b1, e, d, b);
      check("two_latency", 256'(e), 256'(64 / UNRS[i] + 1));
      check("two_busy",    256'(b), 256'd0);
      check("two_dones",   256'(d1 + d), 256'd2);
      check("two_digest",  s_data[i], TWO_D);
      @(posedge clk); #1;
    end

    // Empty message, digest held while s_ready is low and blk_valid offered
    s_ready[0] = 1'b0;
    send_block(0, EMPTY, 1'b1, 1'b1, e, d, b);
    check("empty_latency", 256'(e), 256'd65);
    check("empty_digest",  s_data[0], EMPTY_D);
    blk_data[0]  = ABC;
    blk_first[0] = 1'b1;
    blk_last[0]  = 1'b1;
    blk_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("empty_hold_ctl",  256'({s_valid[0], blk_ready[0]}), 256'd2);
      check("empty_hold_data", s_data[0], EMPTY_D);
    end
    blk_valid[0] = 1'b0;
    s_ready[0]   = 1'b1;
    @(posedge clk); #1;
    check("empty_release", 256'({s_valid[0], blk_ready[0]}), 256'd1);
    @(posedge clk); #1;
    check("empty_no_accept", 256'(blk_ready[0]), 256'd1);

    // Reset in the middle of the rounds, then "abc" without blk_first
    blk_data[0]  = ABC;
    blk_first[0] = 1'b1;
    blk_last[0]  = 1'b1;
    blk_valid[0] = 1'b1;
    @(posedge clk); #1;
    blk_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", 256'(blk_ready[0]), 256'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready",  256'(blk_ready[0]), 256'd1);
    check("mid_rst_svalid", 256'(s_valid[0]),   256'd0);
    check("mid_rst_done",   256'(hash_done[0]), 256'd0);
    check("mid_rst_data",   s_data[0], IV256_D);
    @(posedge clk); #1;
    reset = 1'b0;
    send_block(0, ABC, 1'b0, 1'b1, e, d, b);
    check("post_rst_latency", 256'(e), 256'd65);
    check("post_rst_digest",  s_data[0], ABC_D);
    @(posedge clk); #1;

    // Restart: first half of a message, then a fresh "abc"
    send_block(0, TWO1, 1'b1, 1'b0, e, d, b);
    check("restart_b1_dones", 256'(d), 256'd1);
    send_block(0, ABC, 1'b1, 1'b1, e, d, b);
    check("restart_digest", s_data[0], ABC_D);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
